// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing constants for the 640x480@60 Hz VGA generator.
//   Contents:
//     H_*/V_* porch/sync/display widths and the derived line/frame totals
//     HSYNC_*/VSYNC_* first and last coordinate of each sync pulse
//     coord_t  10-bit pixel/line coordinate
//     sync_t   bundle of the registered sync/blanking outputs
//     wrapInc  modulo increment used by both coordinate counters
package vga_timing_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int HSYNC_START = H_DISPLAY + H_FRONT;
  localparam int HSYNC_END   = HSYNC_START + H_SYNC - 1;
  localparam int VSYNC_START = V_DISPLAY + V_FRONT;
  localparam int VSYNC_END   = VSYNC_START + V_SYNC - 1;

  localparam int CLK_DIV = 4;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Sync pins are active-low; video_on is active-high.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  // Step a coordinate by one, folding total-1 back to zero.
  function automatic coord_t wrapInc(input coord_t v, input int total);
    if (v == coord_t'(total - 1)) begin
      return '0;
    end
    return v + coord_t'(1);
  endfunction

endpackage

// File: rtl/vga_tick_gen.sv
// vga_tick_gen
//   Divides the system clock down to a one-clock-wide pixel enable that
//   fires once every CLK_DIV clocks. CLK_DIV must be at least 2.
//   Ports:
//     clk     in   system clock
//     reset   in   synchronous, active-high; restarts the divide phase
//     p_tick  out  high for one clk whenever the divider sits at CLK_DIV-1
module vga_tick_gen import vga_timing_pkg::*; #(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Free-running modulo-CLK_DIV phase counter.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (div_q == DIV_W'(CLK_DIV - 1)) begin
      div_d = '0;
    end
  end

  // Phase register; reset puts the tick CLK_DIV-1 clocks away.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Decoded straight from the register, so it is glitch-free and exactly
  // one clk wide.
  assign p_tick = (div_q == DIV_W'(CLK_DIV - 1));

endmodule

// File: rtl/vga_sync.sv
// vga_sync
//   VGA timing generator: pixel-enable divider, horizontal/vertical
//   coordinate counters and registered sync/blanking decode.
//   Ports:
//     clk       in   system clock (100 MHz for 25 MHz pixels at CLK_DIV=4)
//     reset     in   synchronous, active-high
//     hsync     out  horizontal sync, active-low
//     vsync     out  vertical sync, active-low
//     video_on  out  high while (x,y) lies in the visible area
//     p_tick    out  one-clk pixel enable, once every CLK_DIV clocks
//     x         out  current pixel column, 0..H_TOTAL-1
//     y         out  current line, 0..V_TOTAL-1
module vga_sync import vga_timing_pkg::*; #(
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK,
  parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV
) (
  input  logic         clk,
  input  logic         reset,
  output logic         hsync,
  output logic         vsync,
  output logic         video_on,
  output logic         p_tick,
  output logic [9:0]   x,
  output logic [9:0]   y
);

  localparam int H_TOT    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic   tick;
  coord_t x_q, x_d;
  coord_t y_q, y_d;
  sync_t  sync_q, sync_d;

  vga_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .p_tick (tick)
  );

  // Coordinate counters move only on pixel ticks; the line counter steps
  // on the same tick that the column counter wraps.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      x_d = wrapInc(x_q, H_TOT);
      if (x_q == coord_t'(H_TOT - 1)) begin
        y_d = wrapInc(y_q, V_TOT);
      end
    end
  end

  // Decode from the next-state coordinates so the registered outputs
  // change on the very edge that x/y change.
  always_comb begin
    sync_d          = '0;
    sync_d.hsync    = !((x_d >= coord_t'(HS_START)) && (x_d <= coord_t'(HS_END)));
    sync_d.vsync    = !((y_d >= coord_t'(VS_START)) && (y_d <= coord_t'(VS_END)));
    sync_d.video_on = (x_d < coord_t'(H_DISPLAY)) && (y_d < coord_t'(V_DISPLAY));
  end

  // State registers; reset lands on the top-left visible pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      sync_q <= '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b1};
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      sync_q <= sync_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign hsync    = sync_q.hsync;
  assign vsync    = sync_q.vsync;
  assign video_on = sync_q.video_on;
  assign p_tick   = tick;

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync
//   Bench for vga_sync. A full-size instance is checked against a table of
//   hand-computed points on the first lines plus hsync period/width; a
//   shrunken-geometry instance (15x11, divide by 2) is checked every clock
//   against a closed-form position model so whole frames, vsync and the
//   frame wrap are exercised in a few hundred clocks.
module tb_vga_sync;

  logic       clk;
  logic       reset;

  logic       hsync, vsync, videoOn, pTick;
  logic [9:0] xPos, yPos;

  logic       sHsync, sVsync, sVideoOn, sPTick;
  logic [9:0] sXPos, sYPos;

  int assertCount = 0;
  int failCount   = 0;
  int edgeNum     = 0;
  int lastHFall   = -1;
  int lastVFall   = -1;
  logic prevHs    = 1'b1;
  logic prevVs    = 1'b1;

  typedef struct {
    string name;
    int    edgeNum;
    int    x;
    int    y;
    bit    hs;
    bit    vs;
    bit    von;
    bit    pt;
  } vec_t;

  vec_t vecs[13];

  vga_sync dut (
    .clk      (clk),
    .reset    (reset),
    .hsync    (hsync),
    .vsync    (vsync),
    .video_on (videoOn),
    .p_tick   (pTick),
    .x        (xPos),
    .y        (yPos)
  );

  vga_sync #(
    .H_DISPLAY (8),
    .H_FRONT   (2),
    .H_SYNC    (3),
    .H_BACK    (2),
    .V_DISPLAY (4),
    .V_FRONT   (2),
    .V_SYNC    (2),
    .V_BACK    (3),
    .CLK_DIV   (2)
  ) dutSmall (
    .clk      (clk),
    .reset    (reset),
    .hsync    (sHsync),
    .vsync    (sVsync),
    .video_on (sVideoOn),
    .p_tick   (sPTick),
    .x        (sXPos),
    .y        (sYPos)
  );

  // 100 MHz system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack a full output set into one word for a single comparison.
  function automatic logic [23:0] pack(input int xv, input int yv, input bit hs,
                                       input bit vs, input bit von, input bit pt);
    logic [9:0] xw;
    logic [9:0] yw;
    xw = xv[9:0];
    yw = yv[9:0];
    return {xw, yw, hs, vs, von, pt};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edgeNum, actual, expected);
    end
  endtask

  // Closed-form position of the small instance edgeNum clocks after reset.
  task automatic checkSmall();
    int t, ex, ey;
    bit ehs, evs, evon, ept;
    t    = edgeNum / 2;
    ex   = t % 15;
    ey   = (t / 15) % 11;
    ehs  = !(ex >= 10 && ex <= 12);
    evs  = !(ey >= 6 && ey <= 7);
    evon = (ex < 8) && (ey < 4);
    ept  = (edgeNum % 2) == 1;
    checkOutput("smallTrack", 32'(pack(int'(sXPos), int'(sYPos), sHsync, sVsync, sVideoOn, sPTick)),
                32'(pack(ex, ey, ehs, evs, evon, ept)));
  endtask

  // One clock: track edges since reset, run the per-clock checks and the
  // sync period/width measurements.
  task automatic applyStimulus();
    logic r;
    r = reset;
    @(posedge clk);
    #1;
    if (r) begin
      edgeNum   = 0;
      lastHFall = -1;
      lastVFall = -1;
    end else begin
      edgeNum++;
    end
    checkSmall();
    if (prevHs && !hsync) begin
      if (lastHFall >= 0) checkOutput("hsyncPeriod", 32'(edgeNum - lastHFall), 32'd3200);
      lastHFall = edgeNum;
    end
    if (!prevHs && hsync && lastHFall >= 0)
      checkOutput("hsyncWidth", 32'(edgeNum - lastHFall), 32'd384);
    prevHs = hsync;
    if (prevVs && !sVsync) begin
      if (lastVFall >= 0) checkOutput("smallVsyncPeriod", 32'(edgeNum - lastVFall), 32'd330);
      lastVFall = edgeNum;
    end
    if (!prevVs && sVsync && lastVFall >= 0)
      checkOutput("smallVsyncWidth", 32'(edgeNum - lastVFall), 32'd60);
    prevVs = sVsync;
  endtask

  initial begin
    int guard;

    // Full-size expectations: x = e/4 mod 800, y = e/3200, p_tick on e%4==3.
    vecs[0]  = '{"resetState",   0,    0,   0, 1, 1, 1, 0};
    vecs[1]  = '{"firstTick",    3,    0,   0, 1, 1, 1, 1};
    vecs[2]  = '{"firstStep",    4,    1,   0, 1, 1, 1, 0};
    vecs[3]  = '{"lastVisible",  2556, 639, 0, 1, 1, 1, 0};
    vecs[4]  = '{"firstBlank",   2560, 640, 0, 1, 1, 0, 0};
    vecs[5]  = '{"preHsync",     2620, 655, 0, 1, 1, 0, 0};
    vecs[6]  = '{"hsyncStart",   2624, 656, 0, 0, 1, 0, 0};
    vecs[7]  = '{"hsyncEnd",     3004, 751, 0, 0, 1, 0, 0};
    vecs[8]  = '{"postHsync",    3008, 752, 0, 1, 1, 0, 0};
    vecs[9]  = '{"lineEnd",      3199, 799, 0, 1, 1, 0, 1};
    vecs[10] = '{"lineWrap",     3200, 0,   1, 1, 1, 1, 0};
    vecs[11] = '{"line1Hsync",   5824, 656, 1, 0, 1, 0, 0};
    vecs[12] = '{"midFrame",     9200, 700, 2, 0, 1, 0, 0};

    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      guard = 0;
      while (edgeNum < vecs[i].edgeNum && guard < 20000) begin
        applyStimulus();
        guard++;
      end
      if (edgeNum != vecs[i].edgeNum) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: reached edge %0d, expected edge %0d", vecs[i].name, edgeNum, vecs[i].edgeNum);
      end
      checkOutput(vecs[i].name, 32'(pack(int'(xPos), int'(yPos), hsync, vsync, videoOn, pTick)),
                  32'(pack(vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs, vecs[i].von, vecs[i].pt)));
    end

    // Reset mid-frame while hsync is low: everything returns to the
    // top-left state on the next edge.
    reset = 1'b1;
    applyStimulus();
    checkOutput("midReset", 32'(pack(int'(xPos), int'(yPos), hsync, vsync, videoOn, pTick)),
                32'(pack(0, 0, 1, 1, 1, 0)));
    reset = 1'b0;

    // Tick cadence restarts from phase zero after release.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus();
      checkOutput("restartTick", 32'(pTick), (i == 3) ? 32'd1 : 32'd0);
      checkOutput("restartX", 32'(xPos), (i == 4) ? 32'd1 : 32'd0);
    end

    // Let the small instance run a couple more frames after the reset.
    for (int i = 0; i < 700; i++) applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
